// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Tracks in-flight predicted branches between fetch and resolution. Each
// pushed prediction {pred, hist} waits in a circular buffer until the oldest
// one is resolved. On resolution the predictor table is trained one cycle
// later. A wrong prediction also flushes every younger entry and produces the
// corrected global history.
//
// Parameters
//   DEPTH   in-flight prediction slots (power of two, 2..64)
//   HIST_W  global history width (>= 2)
//   CNT_W   statistics counter width
//
// Ports
//   CLK               single clock, rising edge
//   RESET             asynchronous, active-low reset
//   Push              fetch issued a predicted branch this cycle
//   Push_Pred         predicted direction (1 = taken)
//   Push_Hist         history used to index the prediction
//   Resolve           oldest in-flight branch resolved this cycle
//   Resolve_Taken     actual direction
//   Update            table write strobe, one-cycle pulse
//   Update_Index      table index to train (popped history)
//   Update_Taken      direction to train
//   Mispredict        flush request, one-cycle pulse
//   Recover_History   corrected history {Resolve_Taken, hist[HIST_W-1:1]}
//   Full / Empty      occupancy == DEPTH / occupancy == 0
//   Count             occupancy
//   Overflow          sticky: push attempted while full
//   Underflow         sticky: resolve attempted while empty
//   Branch_Count      resolved branches (saturating)
//   Mispredict_Count  mispredicted branches (saturating)
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned HIST_W = 12,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       Push,
   input  logic                       Push_Pred,
   input  logic [HIST_W-1:0]          Push_Hist,
   input  logic                       Resolve,
   input  logic                       Resolve_Taken,
   output logic                       Update,
   output logic [HIST_W-1:0]          Update_Index,
   output logic                       Update_Taken,
   output logic                       Mispredict,
   output logic [HIST_W-1:0]          Recover_History,
   output logic                       Full,
   output logic                       Empty,
   output logic [$clog2(DEPTH):0]     Count,
   output logic                       Overflow,
   output logic                       Underflow,
   output logic [CNT_W-1:0]           Branch_Count,
   output logic [CNT_W-1:0]           Mispredict_Count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CW    = PTR_W + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Entry layout: {pred, hist}
   logic [HIST_W:0]    entry_mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CW-1:0]      occ;

   logic               is_full;
   logic               is_empty;
   logic               resolve_ok;
   logic               push_ok;
   logic               push_acc;
   logic               mispred_now;
   logic [HIST_W:0]    head_entry;
   logic               head_pred;
   logic [HIST_W-1:0]  head_hist;

   // ---------------------------------------------------------------------
   // Status derived only from registered occupancy
   // ---------------------------------------------------------------------
   always_comb begin
      is_full  = (occ == FULL_CNT);
      is_empty = (occ == '0);
   end

   assign Full  = is_full;
   assign Empty = is_empty;
   assign Count = occ;

   // ---------------------------------------------------------------------
   // Acceptance decisions
   // ---------------------------------------------------------------------
   always_comb begin
      head_entry  = entry_mem[rd_ptr];
      head_pred   = head_entry[HIST_W];
      head_hist   = head_entry[HIST_W-1:0];
      resolve_ok  = Resolve && !is_empty;
      mispred_now = resolve_ok && (head_pred != Resolve_Taken);
      // A full queue still takes a push when the head leaves this cycle.
      push_ok     = Push && (!is_full || resolve_ok);
      // A flush discards everything younger, including a same-cycle push.
      push_acc    = push_ok && !mispred_now;
   end

   // ---------------------------------------------------------------------
   // Entry storage (contents need no reset: only read when occupied)
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (push_acc) begin
         entry_mem[wr_ptr] <= {Push_Pred, Push_Hist};
      end
   end

   // ---------------------------------------------------------------------
   // Pointers and occupancy
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (mispred_now) begin
         // Flush: read pointer jumps to the write pointer, queue becomes empty.
         rd_ptr <= wr_ptr;
         occ    <= '0;
      end else begin
         if (push_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (resolve_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_acc, resolve_ok})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Sticky error flags
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         if (Push && is_full && !resolve_ok) begin
            Overflow <= 1'b1;
         end
         if (Resolve && is_empty) begin
            Underflow <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Training / recovery stage (single registered stage)
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Update          <= 1'b0;
         Mispredict      <= 1'b0;
         Update_Index    <= '0;
         Update_Taken    <= 1'b0;
         Recover_History <= '0;
      end else begin
         Update     <= resolve_ok;
         Mispredict <= mispred_now;
         if (resolve_ok) begin
            Update_Index    <= head_hist;
            Update_Taken    <= Resolve_Taken;
            Recover_History <= {Resolve_Taken, head_hist[HIST_W-1:1]};
         end
      end
   end

   // ---------------------------------------------------------------------
   // Saturating statistics
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Branch_Count     <= '0;
         Mispredict_Count <= '0;
      end else begin
         if (resolve_ok && (Branch_Count != '1)) begin
            Branch_Count <= Branch_Count + 1'b1;
         end
         if (mispred_now && (Mispredict_Count != '1)) begin
            Mispredict_Count <= Mispredict_Count + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Structural invariants
   // ---------------------------------------------------------------------
   a_occ_bound : assert property (@(posedge CLK) disable iff (!RESET)
      occ <= FULL_CNT);
   a_mispred_with_update : assert property (@(posedge CLK) disable iff (!RESET)
      Mispredict |-> Update);

endmodule

// File: tb/tb_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_queue
//
// Directed bench for branch_resolve_queue. A second instance with CNT_W=4
// shares the stimulus so counter saturation can be observed.
// -----------------------------------------------------------------------------
module tb_branch_resolve_queue;

   logic        CLK;
   logic        RESET;
   logic        Push;
   logic        Push_Pred;
   logic [11:0] Push_Hist;
   logic        Resolve;
   logic        Resolve_Taken;

   logic        Update;
   logic [11:0] Update_Index;
   logic        Update_Taken;
   logic        Mispredict;
   logic [11:0] Recover_History;
   logic        Full;
   logic        Empty;
   logic [3:0]  Count;
   logic        Overflow;
   logic        Underflow;
   logic [31:0] Branch_Count;
   logic [31:0] Mispredict_Count;

   logic        s_update;
   logic [11:0] s_update_index;
   logic        s_update_taken;
   logic        s_mispredict;
   logic [11:0] s_recover_history;
   logic        s_full;
   logic        s_empty;
   logic [3:0]  s_count;
   logic        s_overflow;
   logic        s_underflow;
   logic [3:0]  s_branch_count;
   logic [3:0]  s_mispredict_count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [11:0] exp_q [$];

   branch_resolve_queue #(.DEPTH(8), .HIST_W(12), .CNT_W(32)) u_dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .Push             (Push),
      .Push_Pred        (Push_Pred),
      .Push_Hist        (Push_Hist),
      .Resolve          (Resolve),
      .Resolve_Taken    (Resolve_Taken),
      .Update           (Update),
      .Update_Index     (Update_Index),
      .Update_Taken     (Update_Taken),
      .Mispredict       (Mispredict),
      .Recover_History  (Recover_History),
      .Full             (Full),
      .Empty            (Empty),
      .Count            (Count),
      .Overflow         (Overflow),
      .Underflow        (Underflow),
      .Branch_Count     (Branch_Count),
      .Mispredict_Count (Mispredict_Count)
   );

   branch_resolve_queue #(.DEPTH(8), .HIST_W(12), .CNT_W(4)) u_sat (
      .CLK              (CLK),
      .RESET            (RESET),
      .Push             (Push),
      .Push_Pred        (Push_Pred),
      .Push_Hist        (Push_Hist),
      .Resolve          (Resolve),
      .Resolve_Taken    (Resolve_Taken),
      .Update           (s_update),
      .Update_Index     (s_update_index),
      .Update_Taken     (s_update_taken),
      .Mispredict       (s_mispredict),
      .Recover_History  (s_recover_history),
      .Full             (s_full),
      .Empty            (s_empty),
      .Count            (s_count),
      .Overflow         (s_overflow),
      .Underflow        (s_underflow),
      .Branch_Count     (s_branch_count),
      .Mispredict_Count (s_mispredict_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, ".Count"},            32'(Count),            32'h0);
      check_val({tag, ".Empty"},            32'(Empty),            32'h1);
      check_val({tag, ".Full"},             32'(Full),             32'h0);
      check_val({tag, ".Update"},           32'(Update),           32'h0);
      check_val({tag, ".Mispredict"},       32'(Mispredict),       32'h0);
      check_val({tag, ".Update_Index"},     32'(Update_Index),     32'h0);
      check_val({tag, ".Update_Taken"},     32'(Update_Taken),     32'h0);
      check_val({tag, ".Recover_History"},  32'(Recover_History),  32'h0);
      check_val({tag, ".Overflow"},         32'(Overflow),         32'h0);
      check_val({tag, ".Underflow"},        32'(Underflow),        32'h0);
      check_val({tag, ".Branch_Count"},     Branch_Count,          32'h0);
      check_val({tag, ".Mispredict_Count"}, Mispredict_Count,      32'h0);
   endtask

   // One clock with the given inputs; returns #1 after the rising edge.
   task automatic cycle(input logic psh, input logic pred, input logic [11:0] hist,
                        input logic res, input logic taken);
      Push          = psh;
      Push_Pred     = pred;
      Push_Hist     = hist;
      Resolve       = res;
      Resolve_Taken = taken;
      @(posedge CLK);
      #1;
      Push    = 1'b0;
      Resolve = 1'b0;
   endtask

   task automatic apply_reset();
      Push    = 1'b0;
      Resolve = 1'b0;
      RESET   = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   initial begin
      RESET = 1'b0; Push = 1'b0; Push_Pred = 1'b0; Push_Hist = '0;
      Resolve = 1'b0; Resolve_Taken = 1'b0;
      #3;
      check_reset_state("por");
      apply_reset();

      // ---- basic train / mispredict ----
      cycle(1'b1, 1'b1, 12'h0A5, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 12'h14B, 1'b0, 1'b0);
      check_val("basic.count2", 32'(Count), 32'd2);
      check_val("basic.upd_idle", 32'(Update), 32'h0);
      cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      check_val("basic.upd1", 32'(Update), 32'h1);
      check_val("basic.idx1", 32'(Update_Index), 32'h0A5);
      check_val("basic.tkn1", 32'(Update_Taken), 32'h1);
      check_val("basic.mis1", 32'(Mispredict), 32'h0);
      check_val("basic.count1", 32'(Count), 32'd1);
      cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      check_val("basic.upd2", 32'(Update), 32'h1);
      check_val("basic.idx2", 32'(Update_Index), 32'h14B);
      check_val("basic.mis2", 32'(Mispredict), 32'h1);
      check_val("basic.rec2", 32'(Recover_History), 32'h8A5);
      check_val("basic.count0", 32'(Count), 32'd0);
      check_val("basic.bc", Branch_Count, 32'd2);
      check_val("basic.mc", Mispredict_Count, 32'd1);
      cycle(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
      check_val("basic.upd_drop", 32'(Update), 32'h0);
      check_val("basic.mis_drop", 32'(Mispredict), 32'h0);
      check_val("basic.idx_hold", 32'(Update_Index), 32'h14B);
      check_val("basic.rec_hold", 32'(Recover_History), 32'h8A5);

      // ---- full / overflow / wrap ----
      apply_reset();
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b1, 12'(12'h100 + i), 1'b0, 1'b0);
         exp_q.push_back(12'(12'h100 + i));
      end
      check_val("full.full", 32'(Full), 32'h1);
      check_val("full.count", 32'(Count), 32'd8);
      cycle(1'b1, 1'b1, 12'h1FF, 1'b0, 1'b0);
      check_val("full.ovf", 32'(Overflow), 32'h1);
      check_val("full.count9", 32'(Count), 32'd8);
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'b1, 12'(12'h200 + k), 1'b1, 1'b1);
         exp_q.push_back(12'(12'h200 + k));
         check_val($sformatf("wrap.upd%0d", k), 32'(Update), 32'h1);
         check_val($sformatf("wrap.idx%0d", k), 32'(Update_Index), 32'(exp_q.pop_front()));
         check_val($sformatf("wrap.cnt%0d", k), 32'(Count), 32'd8);
         check_val($sformatf("wrap.mis%0d", k), 32'(Mispredict), 32'h0);
      end
      check_val("wrap.bc", Branch_Count, 32'd20);
      check_val("wrap.underflow", 32'(Underflow), 32'h0);

      // ---- underflow ----
      apply_reset();
      cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      check_val("unf.upd", 32'(Update), 32'h0);
      check_val("unf.flag", 32'(Underflow), 32'h1);
      check_val("unf.bc", Branch_Count, 32'd0);
      cycle(1'b1, 1'b1, 12'h077, 1'b1, 1'b1);
      check_val("unf.pr_count", 32'(Count), 32'd1);
      check_val("unf.pr_upd", 32'(Update), 32'h0);
      check_val("unf.pr_bc", Branch_Count, 32'd0);

      // ---- flush on mispredict with simultaneous push ----
      apply_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 12'(12'h050 + i), 1'b0, 1'b0);
      check_val("flush.count5", 32'(Count), 32'd5);
      cycle(1'b1, 1'b1, 12'h0EE, 1'b1, 1'b0);
      check_val("flush.mis", 32'(Mispredict), 32'h1);
      check_val("flush.upd", 32'(Update), 32'h1);
      check_val("flush.idx", 32'(Update_Index), 32'h050);
      check_val("flush.tkn", 32'(Update_Taken), 32'h0);
      check_val("flush.rec", 32'(Recover_History), 32'h028);
      check_val("flush.count", 32'(Count), 32'd0);
      check_val("flush.empty", 32'(Empty), 32'h1);
      check_val("flush.ovf", 32'(Overflow), 32'h0);
      cycle(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
      check_val("flush.mis_pulse", 32'(Mispredict), 32'h0);
      check_val("flush.empty2", 32'(Empty), 32'h1);
      cycle(1'b1, 1'b0, 12'h333, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      check_val("flush.next_idx", 32'(Update_Index), 32'h333);
      check_val("flush.next_mis", 32'(Mispredict), 32'h0);

      // ---- asynchronous reset mid-operation ----
      apply_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 12'(12'h0C0 + i), 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      check_val("arst.upd_before", 32'(Update), 32'h1);
      #1;
      RESET = 1'b0;
      #1;
      check_reset_state("arst");
      #1;
      RESET = 1'b1;
      @(posedge CLK); #1;
      check_val("arst.upd_after", 32'(Update), 32'h0);
      check_val("arst.count_after", 32'(Count), 32'd0);
      check_val("arst.empty_after", 32'(Empty), 32'h1);

      // ---- counter saturation (CNT_W=4 instance) ----
      apply_reset();
      for (int i = 1; i <= 17; i++) begin
         cycle(1'b1, 1'b1, 12'(i), 1'b0, 1'b0);
         cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
         if (i == 15) check_val("sat.bc15", 32'(s_branch_count), 32'hF);
         if (i == 16) check_val("sat.bc16", 32'(s_branch_count), 32'hF);
      end
      check_val("sat.bc17", 32'(s_branch_count), 32'hF);
      check_val("sat.mc17", 32'(s_mispredict_count), 32'h0);
      check_val("sat.wide_bc", Branch_Count, 32'd17);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning in-flight prediction slots (power of two, 2..64).
REQ-002 SHALL have parameter HIST_W, default 12, meaning global history width.
REQ-003 SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- Push  in  1  fetch issued a predicted branch this cycle
- Push_Pred  in  1  predicted direction (1 = taken)
- Push_Hist  in  HIST_W  history used to index the prediction
- Resolve  in  1  oldest in-flight branch resolved this cycle
- Resolve_Taken  in  1  actual direction
- Update  out  1  table write strobe, one-cycle pulse
- Update_Index  out  HIST_W  table index to train
- Update_Taken  out  1  direction to train
- Mispredict  out  1  flush request, one-cycle pulse
- Recover_History  out  HIST_W  corrected history {Resolve_Taken, hist[HIST_W-1:1]}
- Full  out  1  occupancy == DEPTH
- Empty  out  1  occupancy == 0
- Count  out  $clog2(DEPTH)+1  occupancy
- Overflow  out  1  sticky: push attempted while full
- Underflow  out  1  sticky: resolve attempted while empty
- Branch_Count  out  CNT_W  resolved branches
- Mispredict_Count  out  CNT_W  mispredicted branches

Function
REQ-005 SHALL hold entries {pred, hist} in a circular buffer with read/write pointers wrapping modulo DEPTH; resolution order equals push order.
REQ-006 SHALL accept Push when not Full, writing at the write pointer and incrementing occupancy at the next edge.
REQ-007 SHALL, on Push while Full with no same-cycle accepted Resolve, drop the entry and set Overflow.
REQ-008 SHALL accept Resolve when not Empty, popping the entry at the read pointer.
REQ-009 SHALL, on Resolve while Empty, ignore it (no Update, no bypass of a same-cycle Push) and set Underflow.
REQ-010 SHALL, when Full with Push and Resolve both asserted and no mispredict, accept both; occupancy unchanged.
REQ-011 SHALL, one cycle after an accepted Resolve, pulse Update for exactly one cycle with Update_Index = popped hist and Update_Taken = Resolve_Taken.
REQ-012 SHALL, when popped pred != Resolve_Taken, pulse Mispredict in the same cycle as Update and drive Recover_History = {Resolve_Taken, popped hist[HIST_W-1:1]}.
REQ-013 SHALL, on a mispredicting Resolve, empty the queue at that edge (younger entries discarded, pointers equalised, Count = 0); a Push in the same cycle is discarded without setting Overflow.
REQ-014 SHALL hold Update_Index, Update_Taken, Recover_History at last values when Update is low.
REQ-015 SHALL increment Branch_Count on each accepted Resolve and Mispredict_Count on each mispredicting one; both saturate at all-ones.
REQ-016 SHALL derive Full, Empty, Count combinationally from registered state, with no dependence on same-cycle inputs.
REQ-017 SHALL have no latency other than the single registered stage in REQ-011/REQ-012.

Reset
REQ-018 SHALL, while RESET is low, immediately force: pointers 0, Count 0, Empty 1, Full 0, Update 0, Mispredict 0, Update_Index 0, Update_Taken 0, Recover_History 0, Overflow 0, Underflow 0, Branch_Count 0, Mispredict_Count 0.
REQ-019 SHALL, on reset asserted mid-operation, discard all in-flight entries and suppress any pending Update/Mispredict pulse.
REQ-020 SHALL resume normal operation on the first rising CLK edge after RESET deasserts.

Verification
REQ-021 Push (pred=1, hist=0x0A5), (pred=0, hist=0x14B); Resolve taken twice -> Update 0x0A5/1 with no Mispredict, then Update 0x14B/1 with Mispredict, Recover_History=0x8A5; Count 0; Branch_Count 2, Mispredict_Count 1.
REQ-022 Push 8 entries with DEPTH=8 -> Full=1, Count=8; 9th Push -> dropped, Overflow=1; Push+correct Resolve same cycle -> Count stays 8, wrap-around order preserved over 20 pushes.
REQ-023 Resolve while Empty -> no Update, Underflow=1, Branch_Count unchanged; Push+Resolve same cycle while Empty -> Count=1, no Update.
REQ-024 Push 5 entries, mispredict on first with simultaneous Push -> Mispredict pulse, Count=0, Empty=1, pushed entry discarded, Overflow=0.
REQ-025 Push 3 entries, resolve one, assert RESET low between edges -> all outputs at REQ-018 values asynchronously; no Update pulse after release.
REQ-026 Force Branch_Count to all-ones (CNT_W=4, 16 resolves) -> 17th resolve leaves Branch_Count=0xF.
